// File: rtl/icache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
// Memory request type codes and the default line-count exponent live here.
package icache_pkg;

    localparam int         INDEX_BITS_DEFAULT = 6;
    localparam logic [2:0] MEM_TYPE_WORD      = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } icache_state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The slave modport is the cache's view; master is the surrounding system.
interface icache_if;

    logic        fetch_req_in;
    logic [31:0] fetch_pc_in;
    logic        fetch_flush_in;
    logic        icache_ready_out;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] inst_pc_out;

    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_out;
    logic        mem_r_nw_out;
    logic [2:0]  mem_type_out;
    logic        mem_activate_out;
    logic [31:0] mem_data_in;
    logic        mem_data_available_in;
    logic        icache_block_in;
    logic        io_buffer_full_in;

    modport slave (
        input  fetch_req_in, fetch_pc_in, fetch_flush_in,
        output icache_ready_out, inst_valid_out, inst_out, inst_pc_out,
        output mem_addr_out, mem_data_out, mem_r_nw_out, mem_type_out, mem_activate_out,
        input  mem_data_in, mem_data_available_in, icache_block_in, io_buffer_full_in
    );

    modport master (
        output fetch_req_in, fetch_pc_in, fetch_flush_in,
        input  icache_ready_out, inst_valid_out, inst_out, inst_pc_out,
        input  mem_addr_out, mem_data_out, mem_r_nw_out, mem_type_out, mem_activate_out,
        output mem_data_in, mem_data_available_in, icache_block_in, io_buffer_full_in
    );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read on the fetch index, one synchronous
// write port for line fills, valid bits cleared by the asynchronous reset.
module icache_array #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 32 - INDEX_BITS - 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_vec;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            logic v_reg;
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    v_reg <= 1'b0;
                end else if (wr_en && (wr_index == INDEX_BITS'(gi))) begin
                    v_reg <= 1'b1;
                end
            end
            assign valid_vec[gi] = v_reg;
        end
    endgenerate

    // Tag and data contents are meaningless until the valid bit is set, so no reset.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_vec[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: one-cycle hits, single-word refill from the
// shared memory controller on a miss, with flush handling via a sticky drop flag.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEFAULT
) (
    input  logic     clk_in,
    input  logic     rst_n_in,
    input  logic     rdy_in,
    icache_if.slave  bus
);

    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    icache_state_t state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [31:0]   addr_reg, addr_next;
    logic          drop_reg, drop_next;
    logic          inst_valid_reg, inst_valid_next;
    logic [31:0]   inst_reg, inst_next;
    logic [31:0]   inst_pc_reg, inst_pc_next;
    logic          fill_en;

    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;
    logic [INDEX_BITS-1:0] fetch_index;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic                  hit;
    logic                  grant;

    assign fetch_index = bus.fetch_pc_in[INDEX_BITS+1:2];
    assign fetch_tag   = bus.fetch_pc_in[31:INDEX_BITS+2];
    assign hit         = rd_valid && (rd_tag == fetch_tag);

    // A data_available seen while still requesting belongs to the LSB, so it blocks grant.
    assign grant = rdy_in && !bus.icache_block_in && !bus.io_buffer_full_in
                   && !bus.mem_data_available_in;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rd_index (fetch_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_en),
        .wr_index (pc_reg[INDEX_BITS+1:2]),
        .wr_tag   (pc_reg[31:INDEX_BITS+2]),
        .wr_data  (bus.mem_data_in)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= '0;
            addr_reg       <= '0;
            drop_reg       <= 1'b0;
            inst_valid_reg <= 1'b0;
            inst_reg       <= '0;
            inst_pc_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            addr_reg       <= addr_next;
            drop_reg       <= drop_next;
            inst_valid_reg <= inst_valid_next;
            inst_reg       <= inst_next;
            inst_pc_reg    <= inst_pc_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        addr_next       = addr_reg;
        drop_next       = drop_reg;
        inst_valid_next = rdy_in ? 1'b0 : inst_valid_reg;
        inst_next       = inst_reg;
        inst_pc_next    = inst_pc_reg;
        fill_en         = 1'b0;

        if (rdy_in) begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.fetch_req_in && !bus.fetch_flush_in) begin
                        if (hit) begin
                            inst_valid_next = 1'b1;
                            inst_next       = rd_data;
                            inst_pc_next    = bus.fetch_pc_in;
                        end else begin
                            pc_next    = bus.fetch_pc_in;
                            addr_next  = word_addr(bus.fetch_pc_in);
                            drop_next  = 1'b0;
                            state_next = ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // A flush coinciding with grant cannot cancel the access; just drop the result.
                    if (grant) begin
                        state_next = ST_WAIT;
                        drop_next  = bus.fetch_flush_in;
                    end else if (bus.fetch_flush_in) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_data_available_in) begin
                        fill_en    = 1'b1;
                        state_next = ST_IDLE;
                        drop_next  = 1'b0;
                        if (!drop_reg && !bus.fetch_flush_in) begin
                            inst_valid_next = 1'b1;
                            inst_next       = bus.mem_data_in;
                            inst_pc_next    = pc_reg;
                        end
                    end else if (bus.fetch_flush_in) begin
                        drop_next = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign bus.icache_ready_out = (state_reg == ST_IDLE);
    assign bus.inst_valid_out   = inst_valid_reg;
    assign bus.inst_out         = inst_reg;
    assign bus.inst_pc_out      = inst_pc_reg;
    assign bus.mem_activate_out = (state_reg == ST_REQ);
    assign bus.mem_addr_out     = addr_reg;
    assign bus.mem_data_out     = 32'h0;
    assign bus.mem_r_nw_out     = 1'b1;
    assign bus.mem_type_out     = MEM_TYPE_WORD;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a table of fetches against a controller model that
// answers four cycles after grant, plus contention, flush, stall and reset cases.
module tb_icache;

    localparam int IB = 6;

    logic clk_in = 1'b0;
    logic rst_n_in;
    logic rdy_in;

    icache_if bus();

    icache #(.INDEX_BITS(IB)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Controller model: memory contents derived from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    int          cd          = 0;
    int          grant_count = 0;
    logic [31:0] granted_addr = '0;
    logic        lsb_pulse;

    always begin
        @(negedge clk_in);
        #1;
        if (!rst_n_in) begin
            cd = 0;
            bus.mem_data_available_in = 1'b0;
            bus.mem_data_in = '0;
        end else if (rdy_in) begin
            bus.mem_data_available_in = 1'b0;
            bus.mem_data_in = 32'hDEAD_BEEF;
            if (cd == 1) begin
                bus.mem_data_available_in = 1'b1;
                bus.mem_data_in = mem_word(granted_addr);
                cd = 0;
            end else if (cd > 1) begin
                cd--;
            end
            if (lsb_pulse) begin
                bus.mem_data_available_in = 1'b1;
                bus.mem_data_in = 32'hBAD0_0BAD;
            end
            if (bus.mem_activate_out && !bus.icache_block_in && !bus.io_buffer_full_in
                && !bus.mem_data_available_in) begin
                cd = 4;
                grant_count++;
                granted_addr = bus.mem_addr_out;
            end
        end
    end

    // Per-cycle side stimulus, indexed by cycles after the request is presented.
    bit blk_s [64];
    bit lsb_s [64];
    bit flush_s [64];
    bit full_s [64];
    bit rdyl_s [64];

    task automatic clear_sched();
        for (int i = 0; i < 64; i++) begin
            blk_s[i] = 0; lsb_s[i] = 0; flush_s[i] = 0; full_s[i] = 0; rdyl_s[i] = 0;
        end
    endtask

    task automatic apply(input int k);
        bus.icache_block_in   = blk_s[k];
        bus.io_buffer_full_in = full_s[k];
        bus.fetch_flush_in    = flush_s[k];
        lsb_pulse             = lsb_s[k];
        rdy_in                = !rdyl_s[k];
    endtask

    // exp_lat = 0 means no instruction pulse is expected.
    task automatic run_fetch(input string name, input logic [31:0] pc, input logic [31:0] exp_inst,
                             input int exp_lat, input int exp_grants);
        int          g0;
        int          lat;
        int          pulses;
        int          window;
        logic [31:0] got_inst;
        logic [31:0] got_pc;
        g0       = grant_count;
        lat      = 0;
        pulses   = 0;
        got_inst = '0;
        got_pc   = '0;
        window   = (exp_lat > 0) ? exp_lat + 3 : 14;
        bus.fetch_req_in = 1'b1;
        bus.fetch_pc_in  = pc;
        apply(0);
        for (int k = 1; k <= window; k++) begin
            @(negedge clk_in);
            bus.fetch_req_in = 1'b0;
            if (bus.inst_valid_out === 1'b1) begin
                pulses++;
                if (lat == 0) begin
                    lat      = k;
                    got_inst = bus.inst_out;
                    got_pc   = bus.inst_pc_out;
                end
            end
            apply(k);
        end
        check32({name, " latency"}, 32'(lat), 32'(exp_lat));
        check32({name, " pulses"}, 32'(pulses), (exp_lat > 0) ? 32'd1 : 32'd0);
        if (exp_lat > 0) begin
            check32({name, " inst"}, got_inst, exp_inst);
            check32({name, " pc"}, got_pc, pc);
        end
        check32({name, " grants"}, 32'(grant_count - g0), 32'(exp_grants));
        if (exp_grants > 0) check32({name, " addr"}, granted_addr, {pc[31:2], 2'b00});
        check32({name, " ready"}, 32'(bus.icache_ready_out), 32'd1);
        $display("txn %-16s pc=%08h lat=%0d inst=%08h grants=%0d", name, pc, lat, got_inst,
                 grant_count - g0);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          lat;
        int          grants;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int g0;
        int pulses;

        vecs[0] = '{32'h0000_1000, 32'h0050_0093,           6, 1};
        vecs[1] = '{32'h0000_1000, 32'h0050_0093,           1, 0};
        vecs[2] = '{32'h0000_1100, mem_word(32'h0000_1100), 6, 1};
        vecs[3] = '{32'h0000_1000, 32'h0050_0093,           6, 1};
        vecs[4] = '{32'h0000_1004, mem_word(32'h0000_1004), 6, 1};
        vecs[5] = '{32'h0000_1004, mem_word(32'h0000_1004), 1, 0};
        vecs[6] = '{32'h0000_1102, mem_word(32'h0000_1100), 6, 1};
        vecs[7] = '{32'h0000_1100, mem_word(32'h0000_1100), 1, 0};

        rst_n_in = 1'b0;
        bus.fetch_req_in = 1'b0;
        bus.fetch_pc_in  = '0;
        clear_sched();
        apply(0);
        repeat (2) @(negedge clk_in);

        check32("rst ready", 32'(bus.icache_ready_out), 32'd1);
        check32("rst valid", 32'(bus.inst_valid_out), 32'd0);
        check32("rst inst", bus.inst_out, 32'h0);
        check32("rst inst_pc", bus.inst_pc_out, 32'h0);
        check32("rst activate", 32'(bus.mem_activate_out), 32'd0);
        check32("rst addr", bus.mem_addr_out, 32'h0);
        check32("const data", bus.mem_data_out, 32'h0);
        check32("const r_nw", 32'(bus.mem_r_nw_out), 32'd1);
        check32("const type", 32'(bus.mem_type_out), 32'd0);
        $display("txn reset");

        rst_n_in = 1'b1;
        @(negedge clk_in);

        for (int i = 0; i < 8; i++) begin
            run_fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].inst, vecs[i].lat, vecs[i].grants);
        end

        // LSB holds the controller for 3 cycles with its own data pulse, then one more pulse.
        clear_sched();
        blk_s[1] = 1; blk_s[2] = 1; blk_s[3] = 1;
        lsb_s[2] = 1; lsb_s[4] = 1;
        run_fetch("lsb_contention", 32'h0000_2000, mem_word(32'h0000_2000), 10, 1);

        clear_sched();
        full_s[1] = 1; full_s[2] = 1;
        run_fetch("io_full", 32'h0000_2400, mem_word(32'h0000_2400), 8, 1);

        // Flush while the request is blocked: no access, back to idle.
        clear_sched();
        apply(0);
        g0 = grant_count;
        bus.fetch_req_in = 1'b1;
        bus.fetch_pc_in  = 32'h0000_3000;
        @(negedge clk_in);
        bus.fetch_req_in = 1'b0;
        check32("flush_req activate", 32'(bus.mem_activate_out), 32'd1);
        bus.icache_block_in = 1'b1;
        bus.fetch_flush_in  = 1'b1;
        @(negedge clk_in);
        check32("flush_req act_drop", 32'(bus.mem_activate_out), 32'd0);
        check32("flush_req ready", 32'(bus.icache_ready_out), 32'd1);
        bus.icache_block_in = 1'b0;
        bus.fetch_flush_in  = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk_in);
            if (bus.inst_valid_out === 1'b1) pulses++;
        end
        check32("flush_req pulses", 32'(pulses), 32'd0);
        check32("flush_req grants", 32'(grant_count - g0), 32'd0);
        $display("txn flush_req        pc=00003000 grants=%0d pulses=%0d", grant_count - g0, pulses);

        clear_sched();
        flush_s[3] = 1;
        run_fetch("flush_wait", 32'h0000_3000, 32'h0, 0, 1);
        clear_sched();
        run_fetch("after_flush_hit", 32'h0000_3000, mem_word(32'h0000_3000), 1, 0);

        clear_sched();
        flush_s[0] = 1;
        run_fetch("flush_idle_hit", 32'h0000_3000, 32'h0, 0, 0);

        clear_sched();
        flush_s[1] = 1;
        run_fetch("flush_on_pulse", 32'h0000_3000, mem_word(32'h0000_3000), 1, 0);

        clear_sched();
        for (int k = 3; k <= 7; k++) rdyl_s[k] = 1;
        run_fetch("rdy_stall", 32'h0000_5000, mem_word(32'h0000_5000), 11, 1);

        // Asynchronous reset in the middle of a refill.
        clear_sched();
        apply(0);
        bus.fetch_req_in = 1'b1;
        bus.fetch_pc_in  = 32'h0000_4000;
        @(negedge clk_in);
        bus.fetch_req_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check32("rst_wait busy", 32'(bus.icache_ready_out), 32'd0);
        rst_n_in = 1'b0;
        #1;
        check32("rst_wait ready", 32'(bus.icache_ready_out), 32'd1);
        check32("rst_wait activate", 32'(bus.mem_activate_out), 32'd0);
        check32("rst_wait valid", 32'(bus.inst_valid_out), 32'd0);
        $display("txn reset_mid_wait   pc=00004000");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        run_fetch("post_rst_5000", 32'h0000_5000, mem_word(32'h0000_5000), 6, 1);
        run_fetch("post_rst_1004", 32'h0000_1004, mem_word(32'h0000_1004), 6, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
